layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Sequences one accelerator layer at a time: accepts a one-hot layer command, drives the datapath path-select and PE-enable lines, starts the selected processing element (PE), and forwards only that PE's DMA read/write start requests to the shared DMA. It then waits for the end-of-layer `last_in` and reports completion or error. It sits between the host command interface and the PE/DMA datapath, and replaces free OR-ing of PE DMA requests with a single granted owner per layer.

## Interface
- `TIMEOUT_W`, 24, width of the watchdog counter and `timeout_limit`.
- `SETTLE`, 2, cycles the selects are held stable before `pe_start` (1..15).

- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  layer command offered
- `cmd_ready`  out  1  high only in IDLE
- `cmd_mode`  in  4  one-hot: 0001 conv3x3, 0010 conv1x1, 0100 reserved, 1000 reshape
- `timeout_limit`  in  TIMEOUT_W  idle-cycle limit in RUN; 0 disables the watchdog
- `sel_path`  out  2  datapath mux select
- `pe_en_n`  out  4  active-low PE enables
- `pe_start`  out  4  one-cycle start pulse to the granted PE
- `pe_read_req`  in  4  per-PE DMA read start requests
- `pe_write_req`  in  4  per-PE DMA write start requests
- `DMA_Read_Start`  out  1  forwarded read start (granted PE only)
- `DMA_Write_Start`  out  1  forwarded write start (granted PE only)
- `last_in`  in  1  end-of-layer from the datapath
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle error pulse
- `err_code`  out  2  01 illegal mode, 10 timeout, 11 stray request; holds until the next accepted command

## Operation
- States: IDLE, CONFIG, START, RUN, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `cmd_mode`.
  - A legal mode is exactly one bit set and not 0100. A legal mode goes to CONFIG.
  - An illegal mode is consumed: `err`=1 and `err_code`=01 next cycle, stay in IDLE, selects unchanged.
- **Mode mapping**, registered on entry to CONFIG (`sel_path` / `pe_en_n` / granted PE):
  - conv3x3: 00 / 1110 / PE0
  - conv1x1: 01 / 1101 / PE1
  - reshape: 11 / 0111 / PE3
- **CONFIG**: hold for `SETTLE` cycles, then go to START.
- **START**: `pe_start[g]`=1 for exactly one cycle, then go to RUN.
- **RUN**
  - `DMA_Read_Start` is a register of `pe_read_req[g]`; `DMA_Write_Start` is a register of `pe_write_req[g]`.
  - Requests on any non-granted bit are dropped. Each dropped request raises `err` with `err_code`=11 for one cycle; the layer continues.
  - The watchdog counter resets to 0 on every forwarded request or `last_in` and increments otherwise.
  - Counter == `timeout_limit` (limit ≠ 0): `err`=1, `err_code`=10, go to IDLE.
  - `last_in` goes to DONE.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- `sel_path`/`pe_en_n` keep the last layer's values after DONE or timeout, until the next legal command.
- `last_in`, `pe_read_req` and `pe_write_req` are ignored outside RUN.

## Timing
- Reset values:
  - State IDLE; `cmd_ready`=1 after reset.
  - `sel_path`=00, `pe_en_n`=1111.
  - `pe_start`, `DMA_Read_Start`, `DMA_Write_Start`, `busy`, `done`, `err` = 0; `err_code`=00; watchdog counter = 0.
- Command accepted at cycle N:
  - `busy` and the selects update at N+1.
  - `pe_start` fires at N+1+`SETTLE` (N+3 at default).
  - RUN begins at N+2+`SETTLE`.
- Request forwarding latency is 1 cycle; back-to-back requests are forwarded back-to-back.
- `last_in` at cycle M in RUN: `done` at M+1, `cmd_ready`=1 at M+2.
- A request arriving in the same cycle as `last_in` is still forwarded at M+1.
- Simultaneous `last_in` and watchdog expiry: `last_in` wins (DONE, no error).
- Simultaneous stray request and `last_in`: both the stray error pulse and DONE occur.
- Watchdog saturates at all-ones; it is never compared while not in RUN.
- `rst` in any state returns to IDLE on the next edge:
  - All outputs take their reset values.
  - Pending forwarded requests are dropped; no `done`/`err` is emitted.

## Test plan
- Reset then `cmd_mode`=0001 at N; `last_in` 10 cycles after RUN -> `sel_path`=00 and `pe_en_n`=1110 at N+1; `pe_start`=0001 at N+3; `done` one cycle after `last_in`; `cmd_ready` one cycle later.
- Reshape (1000); `pe_read_req`=1000 for 3 consecutive cycles, then `pe_read_req`=0001 for 1 cycle -> `DMA_Read_Start` high for 3 cycles, 1 cycle delayed; the PE0 pulse is dropped; `err`=1 with `err_code`=11 once.
- `cmd_mode`=0100, then 0011 -> two `err` pulses with `err_code`=01; `busy` stays 0; `sel_path`/`pe_en_n` unchanged.
- conv1x1 with `timeout_limit`=5 and no requests -> `err` with `err_code`=10 exactly 5 cycles into RUN; IDLE; no `done`.
- Same as the previous case, but `last_in` on the expiry cycle -> `done`=1, `err`=0.
- `rst` asserted mid-RUN while `pe_write_req[g]`=1 -> the next cycle shows IDLE, `DMA_Write_Start`=0 and `pe_en_n`=1111; a new command is then accepted normally.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs one accelerator layer at a time, granting the shared DMA to a single PE, with a watchdog
module layer_sequencer #(
  parameter int TIMEOUT_W = 24,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_mode,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic [1:0]           sel_path,
  output logic [3:0]           pe_en_n,
  output logic [3:0]           pe_start,
  input  logic [3:0]           pe_read_req,
  input  logic [3:0]           pe_write_req,
  output logic                 DMA_Read_Start,
  output logic                 DMA_Write_Start,
  input  logic                 last_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code
);
  typedef enum logic [2:0] {IDLE, CONFIG, START, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] sel_q, sel_d, code_q, code_d, mode_sel;
  logic [3:0] en_n_q, en_n_d, start_q, start_d, settle_q, settle_d, gmask;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d, rd_q, rd_d, wr_q, wr_d;
  logic legal, fwd, stray, expire;
  always_comb begin
    gmask = 4'b0001 << sel_q;
    legal = cmd_mode == 4'b0001 || cmd_mode == 4'b0010 || cmd_mode == 4'b1000;
    mode_sel = cmd_mode[0] ? 2'b00 : cmd_mode[1] ? 2'b01 : 2'b11;
    fwd = pe_read_req[sel_q] | pe_write_req[sel_q];
    stray = |((pe_read_req | pe_write_req) & ~gmask);
    expire = wd_q == timeout_limit && timeout_limit != '0 && !last_in;
    state_d = state_q;
    sel_d = sel_q;
    en_n_d = en_n_q;
    code_d = code_q;
    settle_d = settle_q;
    wd_d = wd_q;
    start_d = '0;
    rd_d = 1'b0;
    wr_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        code_d = legal ? 2'b00 : 2'b01;
        err_d = !legal;
        if (legal) begin
          state_d = CONFIG;
          sel_d = mode_sel;
          en_n_d = ~(4'b0001 << mode_sel);
          settle_d = '0;
        end
      end
      CONFIG: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == 4'(SETTLE - 1)) begin
          state_d = START;
          start_d = gmask;
        end
      end
      START: begin
        state_d = RUN;
        wd_d = '0;
      end
      RUN: begin
        rd_d = pe_read_req[sel_q];
        wr_d = pe_write_req[sel_q];
        wd_d = (fwd || last_in) ? '0 : &wd_q ? wd_q : wd_q + 1'b1;
        err_d = stray || expire;
        code_d = expire ? 2'b10 : stray ? 2'b11 : code_q;
        state_d = last_in ? DONE : expire ? IDLE : RUN;
        done_d = last_in;
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= 2'b00;
      en_n_q <= 4'b1111;
      code_q <= 2'b00;
      settle_q <= '0;
      wd_q <= '0;
      start_q <= '0;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      en_n_q <= en_n_d;
      code_q <= code_d;
      settle_q <= settle_d;
      wd_q <= wd_d;
      start_q <= start_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end
  assign cmd_ready = ready_q;
  assign sel_path = sel_q;
  assign pe_en_n = en_n_q;
  assign pe_start = start_q;
  assign DMA_Read_Start = rd_q;
  assign DMA_Write_Start = wr_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign err_code = code_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: vector table plus scoreboarded RUN cycles for layer_sequencer
module tb_layer_sequencer;
  localparam int SETTLE = 2;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, last_in = 1'b0;
  logic [3:0] cmd_mode = '0, pe_read_req = '0, pe_write_req = '0;
  logic [23:0] timeout_limit = '0;
  logic cmd_ready, DMA_Read_Start, DMA_Write_Start, busy, done, err;
  logic [1:0] sel_path, err_code;
  logic [3:0] pe_en_n, pe_start;
  int n_cmp = 0, n_bad = 0, g = 0, wd = 0;
  typedef struct {logic [3:0] mode; logic legal; logic [1:0] sel; logic [3:0] en_n; logic [3:0] last_rd;} vec_t;
  typedef struct {logic rd; logic wr; logic err; logic done; logic code_chk; logic [1:0] code;} exp_t;
  vec_t vt[7];
  exp_t sb[$];
  layer_sequencer #(.TIMEOUT_W(24), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .timeout_limit(timeout_limit), .sel_path(sel_path), .pe_en_n(pe_en_n), .pe_start(pe_start),
    .pe_read_req(pe_read_req), .pe_write_req(pe_write_req), .DMA_Read_Start(DMA_Read_Start),
    .DMA_Write_Start(DMA_Write_Start), .last_in(last_in), .busy(busy), .done(done), .err(err),
    .err_code(err_code)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic send_cmd(input logic [3:0] m);
    cmd_valid = 1'b1;
    cmd_mode = m;
    tick;
    cmd_valid = 1'b0;
    cmd_mode = '0;
  endtask
  task automatic start_layer(input logic [3:0] m, input logic [1:0] es, input logic [3:0] een);
    send_cmd(m);
    chk("busy_acc", busy, 1);
    chk("ready_acc", cmd_ready, 0);
    chk("sel_acc", sel_path, es);
    chk("en_n_acc", pe_en_n, een);
    chk("code_clr", err_code, 0);
    g = es;
    wd = 0;
    for (int i = 0; i < SETTLE; i++) begin
      chk("pe_start_early", pe_start, 0);
      tick;
    end
    chk("pe_start", pe_start, 32'd1 << g);
    tick;
    chk("pe_start_off", pe_start, 0);
  endtask
  task automatic run_cycle(input logic [3:0] rd, input logic [3:0] wr, input logic last);
    exp_t e;
    logic st, to;
    pe_read_req = rd;
    pe_write_req = wr;
    last_in = last;
    st = |((rd | wr) & ~(4'b0001 << g));
    to = wd == int'(timeout_limit) && timeout_limit != 0 && !last;
    e.rd = rd[g];
    e.wr = wr[g];
    e.err = st | to;
    e.done = last;
    e.code_chk = st | to;
    e.code = to ? 2'b10 : 2'b11;
    wd = (rd[g] || wr[g] || last) ? 0 : wd + 1;
    sb.push_back(e);
    tick;
    pe_read_req = '0;
    pe_write_req = '0;
    last_in = 1'b0;
    e = sb.pop_front();
    chk("dma_rd", DMA_Read_Start, e.rd);
    chk("dma_wr", DMA_Write_Start, e.wr);
    chk("err_run", err, e.err);
    chk("done_run", done, e.done);
    if (e.code_chk) chk("code_run", err_code, e.code);
  endtask
  task automatic end_layer;
    chk("ready_in_done", cmd_ready, 0);
    tick;
    chk("ready_after", cmd_ready, 1);
    chk("busy_after", busy, 0);
    chk("done_once", done, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    vt[0] = '{4'b0001, 1'b1, 2'b00, 4'b1110, 4'b0000};
    vt[1] = '{4'b0100, 1'b0, 2'b00, 4'b1110, 4'b0000};
    vt[2] = '{4'b0010, 1'b1, 2'b01, 4'b1101, 4'b0001};
    vt[3] = '{4'b0011, 1'b0, 2'b01, 4'b1101, 4'b0000};
    vt[4] = '{4'b1000, 1'b1, 2'b11, 4'b0111, 4'b1000};
    vt[5] = '{4'b0000, 1'b0, 2'b11, 4'b0111, 4'b0000};
    vt[6] = '{4'b1100, 1'b0, 2'b11, 4'b0111, 4'b0000};
    tick;
    tick;
    rst = 1'b0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_sel", sel_path, 0);
    chk("rst_en_n", pe_en_n, 4'b1111);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_done", done, 0);
    chk("rst_pe_start", pe_start, 0);
    for (int v = 0; v < 7; v++) begin
      if (vt[v].legal) begin
        start_layer(vt[v].mode, vt[v].sel, vt[v].en_n);
        run_cycle(4'b0001 << g, 4'b0000, 1'b0);
        run_cycle(4'b0000, 4'b0001 << g, 1'b0);
        for (int i = 0; i < 10; i++) run_cycle(4'b0000, 4'b0000, 1'b0);
        run_cycle(vt[v].last_rd, 4'b0000, 1'b1);
        end_layer;
        chk("sel_held", sel_path, vt[v].sel);
        chk("en_n_held", pe_en_n, vt[v].en_n);
      end else begin
        send_cmd(vt[v].mode);
        chk("ill_err", err, 1);
        chk("ill_code", err_code, 2'b01);
        chk("ill_busy", busy, 0);
        chk("ill_ready", cmd_ready, 1);
        chk("ill_sel", sel_path, vt[v].sel);
        chk("ill_en_n", pe_en_n, vt[v].en_n);
        tick;
        chk("ill_err_once", err, 0);
        chk("ill_code_hold", err_code, 2'b01);
      end
    end
    start_layer(4'b1000, 2'b11, 4'b0111);
    for (int i = 0; i < 3; i++) run_cycle(4'b1000, 4'b0000, 1'b0);
    run_cycle(4'b0001, 4'b0000, 1'b0);
    run_cycle(4'b0000, 4'b0000, 1'b0);
    run_cycle(4'b0000, 4'b0000, 1'b1);
    end_layer;
    timeout_limit = 24'd5;
    start_layer(4'b0010, 2'b01, 4'b1101);
    for (int i = 0; i < 5; i++) run_cycle(4'b0000, 4'b0000, 1'b0);
    run_cycle(4'b0000, 4'b0000, 1'b0);
    chk("to_ready", cmd_ready, 1);
    chk("to_busy", busy, 0);
    tick;
    chk("to_no_done", done, 0);
    chk("to_err_once", err, 0);
    start_layer(4'b0010, 2'b01, 4'b1101);
    for (int i = 0; i < 5; i++) run_cycle(4'b0000, 4'b0000, 1'b0);
    run_cycle(4'b0000, 4'b0000, 1'b1);
    end_layer;
    timeout_limit = '0;
    start_layer(4'b0001, 2'b00, 4'b1110);
    run_cycle(4'b0000, 4'b0001, 1'b0);
    run_cycle(4'b0010, 4'b0000, 1'b0);
    pe_write_req = 4'b0001;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    pe_write_req = '0;
    chk("mid_rst_wr", DMA_Write_Start, 0);
    chk("mid_rst_en_n", pe_en_n, 4'b1111);
    chk("mid_rst_sel", sel_path, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_code", err_code, 0);
    chk("mid_rst_err", err, 0);
    tick;
    chk("post_rst_wr", DMA_Write_Start, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_err", err, 0);
    start_layer(4'b0010, 2'b01, 4'b1101);
    run_cycle(4'b0000, 4'b0010, 1'b0);
    run_cycle(4'b0000, 4'b0000, 1'b1);
    end_layer;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
